block_hit_judge: RTL and testbench
==================================

Name: block_hit_judge

Overview:
- Consumer end of the block field produced by the random block generator.
- Reads the bottom row of the 64-bit display field and judges player key presses against it as hits or wrong presses.
- Judges uncleared blocks leaving the bottom row as misses.
- Keeps score, combo and lives; pulses a lane-clear mask back to the generator.
- Sits between the generator, the debounced key inputs and the score/LED display logic.

Parameters:
- LIVES, 3, initial lives at game start (1..3, fits 2 bits).
- SCORE_W, 16, score counter width; saturates at all-ones.
- COMBO_W, 8, combo counter width; saturates at all-ones.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  level; starts or restarts a game.
- Disp_num  input  64  block field; row r = Disp_num[8r+7:8r]; row 0 is the bottom; lanes = row bits [3:0]; bits [7:4] ignored.
- row_adv  input  1  one-cycle pulse; the generator shifts the field down on the next cycle.
- key  input  4  debounced key levels, one per lane.
- clr_lane  output  4  one-cycle mask of bottom-row lanes to clear in the generator.
- hit  output  1  one-cycle pulse; at least one lane hit this cycle.
- miss  output  1  one-cycle pulse; a row left with uncleared blocks.
- score  output  SCORE_W  accumulated score.
- combo  output  COMBO_W  consecutive hits since the last miss or wrong press.
- lives  output  2  remaining lives.
- game_over  output  1  high in state OVER.

Behaviour:
- Reset (sync, rst=1): state IDLE; score=0, combo=0, lives=LIVES, cleared mask=0, key history=0. clr_lane, hit, miss and game_over are all 0.
- Edge detect: press[l] = key[l] & ~key_q[l]; key_q registers every cycle in all states.
- States:
  - IDLE -> PLAY when start=1. On entry: score=0, combo=0, lives=LIVES, cleared=0.
  - PLAY -> OVER when lives reaches 0.
  - OVER -> PLAY when start=1, with the same reinitialisation as IDLE -> PLAY.
- In IDLE and OVER, presses and row_adv are ignored; all pulse outputs stay 0.
- Judgement in PLAY, registered with 1-cycle latency from the press edge:
  - Define avail = Disp_num[3:0] & ~cleared.
  - hitmask = press & avail.
  - wrong = press & ~avail (nonzero = wrong press).
- hitmask != 0:
  - clr_lane = hitmask; hit=1.
  - cleared |= hitmask.
  - score += popcount(hitmask), saturating.
  - combo += popcount(hitmask), saturating, unless wrong != 0 in the same cycle; then combo=0 and the hits still score.
- wrong != 0 with hitmask == 0: combo=0. No life is lost.
- row_adv in PLAY: rem = Disp_num[3:0] & ~(cleared | hitmask), where hitmask is this cycle's.
  - Same-cycle press and row_adv: the press is judged first, against the pre-shift row.
  - rem != 0: miss=1, combo=0, lives -= 1 once per row regardless of lane count.
  - cleared=0 after every row_adv.
- lives goes 1 -> 0: next state OVER; game_over=1 from the following cycle. score and combo hold their values.
- start held high in PLAY has no effect.
- rst mid-game overrides everything, including pending pulses.
- Widths: popcount is 3 bits, zero-extended before the add. Saturation compares against the all-ones value before the add.

Decomposition:
- Shared package: ROW_W=8, LANES=4, state encoding {IDLE, PLAY, OVER}, bottom-row slice constants.
- Sub-module: key_edge_detect (4-bit register plus rising-edge mask).

Test Plan:
1. rst=1 for 3 cycles, then start=1 -> state PLAY, score=0, combo=0, lives=3, all pulses 0.
2. Disp_num[3:0]=4'b0010, press key[1] -> next cycle hit=1, clr_lane=4'b0010, score=1, combo=1. A second key[1] press before row_adv -> wrong: combo=0, score stays 1.
3. Disp_num[3:0]=4'b0101, press only key[0], then row_adv -> miss=1, lives=2, combo=0, cleared mask reset to 0.
4. Same cycle: key[2] press and row_adv with bottom row 4'b0100 -> hit=1, miss=0, score+1, lives unchanged.
5. Three rows with uncleared blocks -> lives 3->2->1->0, game_over=1 a cycle after the third miss; later presses give no hit and no score change. start=1 -> PLAY, score=0, lives=3.
6. score preset near 16'hFFFE, press keys 4'b1111 against bottom row 4'b1111 -> score=16'hFFFF (saturated), combo += 4, clr_lane=4'b1111.

Source files
------------

// File: rtl/block_hit_judge_pkg.sv
// Shared constants, state encoding and lane popcount for the block hit judge.
package block_hit_judge_pkg;

  localparam int unsigned ROW_W   = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned DISP_W  = 64;
  localparam int unsigned ROW0_LO = 0;
  localparam int unsigned POP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Number of set lanes in a mask.
  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] m);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      c = c + POP_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/block_hit_judge_key_edge_detect.sv
// Registers the debounced key levels and flags rising edges per lane.
module key_edge_detect #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key,
  output logic [W-1:0] press_c
);

  logic [W-1:0] key_q;

  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else     key_q <= key;
  end

  assign press_c = key & ~key_q;

endmodule

// File: rtl/block_hit_judge.sv
// Judges key presses against the bottom display row; tracks score, combo and lives.
module block_hit_judge
  import block_hit_judge_pkg::*;
#(
  parameter int unsigned LIVES   = 3,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned COMBO_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DISP_W-1:0]    Disp_num,
  input  logic                 row_adv,
  input  logic [LANES-1:0]     key,
  output logic [LANES-1:0]     clr_lane,
  output logic                 hit,
  output logic                 miss,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic [1:0]           lives,
  output logic                 game_over
);

  state_e             state, state_nxt;
  logic [LANES-1:0]   cleared;
  logic [LANES-1:0]   press;
  logic [LANES-1:0]   row0, avail, hitmask, wrong, rem;
  logic [POP_W-1:0]   pop;
  logic [SCORE_W:0]   score_sum;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [COMBO_W-1:0] combo_sat, combo_nxt;
  logic               row_missed;
  logic               disp_unused;

  key_edge_detect #(.W(LANES)) u_key_edge (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .press_c (press)
  );

  assign row0        = Disp_num[ROW0_LO +: LANES];
  assign disp_unused = ^Disp_num[DISP_W-1:LANES];

  // Presses are judged against the pre-shift row; the row check sees this cycle's hits.
  always_comb begin
    avail      = row0 & ~cleared;
    hitmask    = press & avail;
    wrong      = press & ~avail;
    rem        = row0 & ~(cleared | hitmask);
    row_missed = row_adv && (rem != '0);
    pop        = popcount(hitmask);
    score_sum  = {1'b0, score} + (SCORE_W+1)'(pop);
    combo_sum  = {1'b0, combo} + (COMBO_W+1)'(pop);
    score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sat  = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];

    combo_nxt = combo;
    if (wrong != '0)        combo_nxt = '0;
    else if (hitmask != '0) combo_nxt = combo_sat;
    if (row_missed)         combo_nxt = '0;

    state_nxt = state;
    case (state)
      ST_IDLE, ST_OVER: if (start) state_nxt = ST_PLAY;
      ST_PLAY:          if (row_missed && lives == 2'd1) state_nxt = ST_OVER;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      score     <= '0;
      combo     <= '0;
      lives     <= 2'(LIVES);
      cleared   <= '0;
      clr_lane  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      game_over <= (state_nxt == ST_OVER);
      clr_lane  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score   <= '0;
            combo   <= '0;
            lives   <= 2'(LIVES);
            cleared <= '0;
          end
        end
        ST_PLAY: begin
          clr_lane <= hitmask;
          hit      <= (hitmask != '0);
          score    <= score_sat;
          combo    <= combo_nxt;
          cleared  <= row_adv ? '0 : (cleared | hitmask);
          if (row_missed) begin
            miss  <= 1'b1;
            lives <= lives - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_hit_judge.sv
// Self-checking bench for block_hit_judge: directed table, saturation run, random vs model.
module tb_block_hit_judge;

  localparam int LIVES_I = 3;
  localparam int SMAX    = 65535;
  localparam int CMAX    = 255;

  logic        clk, rst, start, row_adv;
  logic [63:0] disp;
  logic [3:0]  key;
  logic [3:0]  clr_lane;
  logic        hit, miss, game_over;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [1:0]  lives;

  int n_cmp = 0;
  int n_bad = 0;

  block_hit_judge #(.LIVES(3), .SCORE_W(16), .COMBO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Disp_num  (disp),
    .row_adv   (row_adv),
    .key       (key),
    .clr_lane  (clr_lane),
    .hit       (hit),
    .miss      (miss),
    .score     (score),
    .combo     (combo),
    .lives     (lives),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: game rules tracked with plain integers and a per-lane array.
  int   m_st;       // 0 idle, 1 playing, 2 over
  int   m_score, m_combo, m_lives;
  bit   m_cleared [4];
  bit   m_kq [4];
  logic [3:0] m_clr;
  bit   m_hit, m_miss, m_go;

  task automatic model_step();
    int n_hit;
    bit any_wrong, any_rem;
    bit pr [4];
    for (int l = 0; l < 4; l++) begin
      pr[l]   = key[l] && !m_kq[l];
      m_kq[l] = rst ? 1'b0 : key[l];
    end
    m_clr = 4'd0; m_hit = 0; m_miss = 0;
    if (rst) begin
      m_st = 0; m_score = 0; m_combo = 0; m_lives = LIVES_I;
      for (int l = 0; l < 4; l++) m_cleared[l] = 0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_score = 0; m_combo = 0; m_lives = LIVES_I;
        for (int l = 0; l < 4; l++) m_cleared[l] = 0;
      end
    end else begin
      n_hit = 0; any_wrong = 0;
      for (int l = 0; l < 4; l++) begin
        if (pr[l]) begin
          if (disp[l] && !m_cleared[l]) begin
            n_hit++; m_cleared[l] = 1; m_clr[l] = 1'b1;
          end else begin
            any_wrong = 1;
          end
        end
      end
      m_hit   = (n_hit > 0);
      m_score = (m_score + n_hit > SMAX) ? SMAX : m_score + n_hit;
      if (any_wrong) m_combo = 0;
      else m_combo = (m_combo + n_hit > CMAX) ? CMAX : m_combo + n_hit;
      if (row_adv) begin
        any_rem = 0;
        for (int l = 0; l < 4; l++) if (disp[l] && !m_cleared[l]) any_rem = 1;
        if (any_rem) begin
          m_miss = 1; m_combo = 0; m_lives--;
          if (m_lives == 0) m_st = 2;
        end
        for (int l = 0; l < 4; l++) m_cleared[l] = 0;
      end
    end
    m_go = (m_st == 2);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit a, input logic [3:0] row, input logic [3:0] k);
    rst = r; start = s; row_adv = a; key = k;
    disp = {56'hDEAD_BEEF_CAFE_12, 4'hF, row};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".clr_lane"},  clr_lane,  m_clr);
    chk({tag, ".hit"},       hit,       m_hit);
    chk({tag, ".miss"},      miss,      m_miss);
    chk({tag, ".score"},     score,     m_score);
    chk({tag, ".combo"},     combo,     m_combo);
    chk({tag, ".lives"},     lives,     m_lives);
    chk({tag, ".game_over"}, game_over, m_go);
  endtask

  typedef struct {
    bit         r, s, a;
    logic [3:0] row, k;
    logic [3:0] e_clr;
    bit         e_hit, e_miss;
    int         e_score, e_combo, e_lives;
    bit         e_go;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit a, logic [3:0] row, logic [3:0] k,
                              logic [3:0] ec, bit eh, bit em, int es, int eco, int el, bit eg);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.row = row; v.k = k;
    v.e_clr = ec; v.e_hit = eh; v.e_miss = em;
    v.e_score = es; v.e_combo = eco; v.e_lives = el; v.e_go = eg;
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    //           r  s  a  row      key      clr      h  m  sc co lv go
    tbl[0]  = mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[1]  = mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[2]  = mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[3]  = mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[4]  = mk(0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 1, 0, 1, 1, 3, 0);
    tbl[5]  = mk(0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 1, 1, 3, 0);
    tbl[6]  = mk(0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 0, 0, 1, 0, 3, 0);
    tbl[7]  = mk(0, 0, 1, 4'b0010, 4'b0000, 4'b0000, 0, 0, 1, 0, 3, 0);
    tbl[8]  = mk(0, 0, 0, 4'b0101, 4'b0001, 4'b0001, 1, 0, 2, 1, 3, 0);
    tbl[9]  = mk(0, 0, 1, 4'b0101, 4'b0000, 4'b0000, 0, 1, 2, 0, 2, 0);
    tbl[10] = mk(0, 0, 1, 4'b0100, 4'b0100, 4'b0100, 1, 0, 3, 1, 2, 0);
    tbl[11] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 3, 1, 2, 0);
    tbl[12] = mk(0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 1, 3, 0, 1, 0);
    tbl[13] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 1, 3, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 3, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 3, 0, 0, 1);
    tbl[16] = mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[17] = mk(0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 1, 1, 3, 0);
    tbl[18] = mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[19] = mk(0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[20] = mk(0, 0, 0, 4'b0011, 4'b0101, 4'b0001, 1, 0, 1, 0, 3, 0);
    tbl[21] = mk(0, 0, 1, 4'b0011, 4'b0000, 4'b0000, 0, 1, 1, 0, 2, 0);
    tbl[22] = mk(1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[23] = mk(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 3, 0);
    tbl[24] = mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 0, 3, 0);

    m_st = 0; m_score = 0; m_combo = 0; m_lives = LIVES_I;
    for (int l = 0; l < 4; l++) begin m_cleared[l] = 0; m_kq[l] = 0; end
    drive(1, 0, 0, 4'b0000, 4'b0000);

    // Directed table: hit, wrong press, miss, same-cycle press+advance, game over, restart.
    for (int i = 0; i < 25; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].row, tbl[i].k);
      tick();
      chk({t, ".clr_lane"},  clr_lane,  tbl[i].e_clr);
      chk({t, ".hit"},       hit,       tbl[i].e_hit);
      chk({t, ".miss"},      miss,      tbl[i].e_miss);
      chk({t, ".score"},     score,     tbl[i].e_score);
      chk({t, ".combo"},     combo,     tbl[i].e_combo);
      chk({t, ".lives"},     lives,     tbl[i].e_lives);
      chk({t, ".game_over"}, game_over, tbl[i].e_go);
    end

    // Saturation: pump the score to 65532 with four-lane hits, then walk to the ceiling.
    drive(1, 0, 0, 4'b0000, 4'b0000); tick();
    drive(0, 1, 0, 4'b0000, 4'b0000); tick();
    for (int i = 0; i < 16383; i++) begin
      drive(0, 0, 0, 4'b1111, 4'b1111); tick();
      drive(0, 0, 1, 4'b1111, 4'b0000); tick();
    end
    chk("sat.score_pump", score, 65532);
    chk("sat.combo_cap",  combo, 255);
    chk("sat.lives_pump", lives, 3);
    drive(0, 0, 0, 4'b0000, 4'b0001); tick();
    chk("sat.wrong_combo", combo, 0);
    chk("sat.wrong_hit",   hit,   0);
    drive(0, 0, 0, 4'b0000, 4'b0000); tick();
    drive(0, 0, 0, 4'b0011, 4'b0011); tick();
    chk("sat.score_fffe", score, 16'hFFFE);
    chk("sat.combo_2",    combo, 2);
    drive(0, 0, 1, 4'b0011, 4'b0000); tick();
    chk("sat.no_miss", miss, 0);
    drive(0, 0, 0, 4'b1111, 4'b1111); tick();
    chk("sat.score_ffff", score, 16'hFFFF);
    chk("sat.combo_6",    combo, 6);
    chk("sat.clr_all",    clr_lane, 4'b1111);
    chk("sat.hit",        hit, 1);
    drive(0, 0, 1, 4'b1111, 4'b0000); tick();
    drive(0, 0, 0, 4'b1111, 4'b1111); tick();
    chk("sat.score_hold", score, 16'hFFFF);
    chk("sat.combo_10",   combo, 10);

    // Random stimulus against the model.
    drive(1, 0, 0, 4'b0000, 4'b0000); tick();
    chk_model("rnd_reset");
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 15) == 0);
      row_adv = ($urandom_range(0, 3) == 0);
      key     = 4'($urandom);
      disp    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) disp[3:0] = disp[3:0] & 4'($urandom);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
